hight_key_sched: RTL and testbench
==================================

# hight_key_sched

Parametrised HIGHT key-schedule engine generating the two 32-bit whitening-key words and all 128 round subkeys from a 128-bit master key. Subkeys are streamed over a valid/ready port, LANES bytes per beat. Encrypt mode streams them in ascending order; decrypt mode streams them in descending group order. It sits between the key register and the HIGHT round datapath, which consumes one beat per round step.

## Interface
- LANES, 4: subkey bytes per beat; legal values are 1, 2 and 4. NB = 128/LANES beats per schedule.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a schedule; ignored unless idle
- ed  in  1  mode, sampled with start: 1 = encrypt, 0 = decrypt
- MK  in  128  master key, sampled with start; byte k = MK[8k+7:8k]
- wk_pre  out  32  input whitening word, {WK3,WK2,WK1,WK0}
- wk_post  out  32  output whitening word, {WK7,WK6,WK5,WK4}
- sk_data  out  8*LANES  subkey beat; lane k occupies bits [8k+7:8k]
- sk_valid  out  1  sk_data valid
- sk_ready  in  1  consumer accepts the beat
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Delta sequence: 7-bit LFSR with s(i+7) = s(i+3) xor s(i).
  - delta0 = 0x5A.
  - delta_i = {s(i+6)..s(i)}, zero-extended to 8 bits.
  - The LFSR steps both forward and backward, LANES steps per accepted beat.
- Subkey rule, for i, j in 0..7:
  - SK[16i+j] = MK[(j-i) mod 8] + delta[16i+j]
  - SK[16i+j+8] = MK[((j-i) mod 8)+8] + delta[16i+j+8]
  - Additions are mod 256.
- Beat ordering:
  - Beat b carries group g: g = b when encrypting, g = NB-1-b when decrypting.
  - Lane k of the beat holds SK[LANES*g + k].
- Whitening words:
  - Encrypt: wk_pre = {MK15,MK14,MK13,MK12}, wk_post = {MK3,MK2,MK1,MK0}.
  - Decrypt: the two words are swapped.
- FSM states:
  - IDLE: waits for start; start latches MK and ed, moves to LOAD.
  - LOAD: loads wk_pre/wk_post and seeds the LFSR. Seed is delta0 for encrypt and the constant delta127 for decrypt (delta127 = the LFSR advanced 127 steps from 0x5A). Moves to STREAM.
  - STREAM: sk_valid = 1. On each handshake (sk_valid && sk_ready), b increments and the LFSR steps. After beat NB-1 is accepted, moves to DONE.
  - DONE: done = 1 for one cycle, then returns to IDLE.
- busy = 1 in LOAD, STREAM and DONE.
- sk_data is a pure function of the latched key, mode and b. It holds stable while sk_valid && !sk_ready.
- MK and ed changes after start have no effect until the next start.
- start is ignored while busy, including in the DONE cycle.
- Reset at any time: FSM goes to IDLE, and all outputs go to 0 on the next edge. An in-flight schedule is abandoned without a done pulse.

## Timing
- Reset values: wk_pre = 0, wk_post = 0, sk_data = 0, sk_valid = 0, busy = 0, done = 0.
- start sampled at edge T:
  - busy = 1 from T+1.
  - wk_pre/wk_post valid from T+2. They are held until the next start's LOAD or a reset.
  - First sk_valid at T+2.
- Sustained throughput is one beat per cycle while sk_ready = 1. With sk_ready held high, the last beat is accepted at edge T+1+NB.
- done is high in the cycle following acceptance of the last beat. busy drops together with done.
- No combinational path from sk_ready to sk_valid or sk_data.

## Configuration
- HIGHT_KS_DELTA_ROM_EN defined:
  - Deltas come from a 128-entry constant ROM indexed by subkey number; the LFSR is removed.
  - The LOAD state is eliminated: wk words and the first sk_valid appear at T+1.
  - The last beat with sk_ready held high is accepted at T+NB, one cycle earlier than the LFSR build.
  - All data values are identical to the LFSR build.
- Undefined: LFSR implementation with the timing given above.

## Test plan
- LANES=4, MK=0, encrypt -> beat 0 = 0x1B366D5A, beat 1 = 0x4103060D; 32 beats total; done pulses once; wk_pre = wk_post = 0.
- LANES=4, MK byte k = k, encrypt -> wk_pre = 0x0F0E0D0C, wk_post = 0x03020100, beat 0 = 0x1E386E5A. All 32 beats match a reference model of the SK rule.
- Same key, decrypt -> wk words swapped. Beat b equals encrypt beat 31-b for all b; for example, the last beat = 0x1E386E5A.
- LANES=1, MK=0, random sk_ready stalls -> 128 beats 0x5A, 0x6D, 0x36, 0x1B, ...; sk_data holds stable during stalls; no beat lost or duplicated.
- start pulsed during STREAM with a different MK and ed -> ignored; the stream continues unchanged.
- reset asserted at beat 10 -> next cycle all outputs are 0 and there is no done pulse. A new start then runs a full schedule from beat 0.

Source files
------------

// File: rtl/hight_key_sched.sv
// HIGHT key schedule: whitening words plus 128 round subkeys streamed LANES bytes per beat.
// Define HIGHT_KS_DELTA_ROM_EN to take deltas from a constant ROM instead of the LFSR.
module hight_key_sched #(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ed,
  input  logic [127:0]       MK,
  output logic [31:0]        wk_pre,
  output logic [31:0]        wk_post,
  output logic [8*LANES-1:0] sk_data,
  output logic               sk_valid,
  input  logic               sk_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned NB = 128 / LANES;
  localparam int unsigned BW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  localparam logic [6:0] Delta0 = 7'h5A;

  // One forward step of s(i+7) = s(i+3) ^ s(i); delta bit 0 is the oldest bit.
  function automatic logic [6:0] lfsr_fwd(input logic [6:0] d);
    return {d[3] ^ d[0], d[6:1]};
  endfunction

`ifdef HIGHT_KS_DELTA_ROM_EN
  function automatic logic [128*7-1:0] gen_rom();
    logic [128*7-1:0] rom;
    logic [6:0]       d;
    rom = '0;
    d   = Delta0;
    for (int n = 0; n < 128; n++) begin
      rom[7*n +: 7] = d;
      d             = lfsr_fwd(d);
    end
    return rom;
  endfunction

  localparam logic [128*7-1:0] DeltaRom = gen_rom();
`else
  // Inverse step: recover s(i) from s(i+7) ^ s(i+3).
  function automatic logic [6:0] lfsr_bwd(input logic [6:0] d);
    return {d[5:0], d[6] ^ d[2]};
  endfunction

  function automatic logic [6:0] lfsr_adv(input logic [6:0] d, input int unsigned n);
    logic [6:0] r;
    r = d;
    for (int unsigned s = 0; s < n; s++) begin
      r = lfsr_fwd(r);
    end
    return r;
  endfunction

  localparam logic [6:0] Delta127 = lfsr_adv(Delta0, 127);
`endif

  state_e        state_q, state_d;
  logic [127:0]  key_q;
  logic          ed_q;
  logic [BW-1:0] b_q;
  logic [31:0]   wk_pre_q, wk_post_q;
  logic          hs;
  logic          last_beat;

  assign hs        = (state_q == StStream) && sk_ready;
  assign last_beat = (b_q == BW'(NB - 1));
  assign wk_pre    = wk_pre_q;
  assign wk_post   = wk_post_q;

`ifndef HIGHT_KS_DELTA_ROM_EN
  // Encrypt: lfsr_q holds the delta of the group's first lane.
  // Decrypt: lfsr_q holds the delta of the group's last lane.
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_step;

  always_comb begin
    lfsr_step = lfsr_q;
    for (int unsigned s = 0; s < LANES; s++) begin
      lfsr_step = ed_q ? lfsr_fwd(lfsr_step) : lfsr_bwd(lfsr_step);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    sk_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
`ifdef HIGHT_KS_DELTA_ROM_EN
          state_d = StStream;
`else
          state_d = StLoad;
`endif
        end
      end
      StLoad: begin
        state_d = StStream;
      end
      StStream: begin
        sk_valid = 1'b1;
        if (sk_ready && last_beat) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      key_q     <= '0;
      ed_q      <= 1'b0;
      b_q       <= '0;
      wk_pre_q  <= '0;
      wk_post_q <= '0;
`ifndef HIGHT_KS_DELTA_ROM_EN
      lfsr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        key_q <= MK;
        ed_q  <= ed;
        b_q   <= '0;
`ifdef HIGHT_KS_DELTA_ROM_EN
        wk_pre_q  <= ed ? MK[127:96] : MK[31:0];
        wk_post_q <= ed ? MK[31:0] : MK[127:96];
`endif
      end
`ifndef HIGHT_KS_DELTA_ROM_EN
      if (state_q == StLoad) begin
        wk_pre_q  <= ed_q ? key_q[127:96] : key_q[31:0];
        wk_post_q <= ed_q ? key_q[31:0] : key_q[127:96];
        lfsr_q    <= ed_q ? Delta0 : Delta127;
      end
      if (hs) begin
        lfsr_q <= lfsr_step;
      end
`endif
      if (hs) begin
        b_q <= b_q + BW'(1);
      end
    end
  end

  // Subkey n = 16i + 8h + j uses key byte 8h + ((j - i) mod 8).
  always_comb begin
    logic [BW-1:0] g;
    logic [6:0]    n;
    logic [6:0]    dl;
    logic [3:0]    idx;
    sk_data = '0;
    n       = '0;
    idx     = '0;
    g       = ed_q ? b_q : ~b_q;
`ifdef HIGHT_KS_DELTA_ROM_EN
    dl = '0;
`else
    dl = lfsr_q;
    if (!ed_q) begin
      for (int unsigned s = 1; s < LANES; s++) begin
        dl = lfsr_bwd(dl);
      end
    end
`endif
    if (state_q == StStream) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        n = 7'(LANES * g + k);
`ifdef HIGHT_KS_DELTA_ROM_EN
        dl = DeltaRom[7*n +: 7];
`endif
        idx               = {n[3], n[2:0] - n[6:4]};
        sk_data[8*k +: 8] = key_q[8*idx +: 8] + {1'b0, dl};
`ifndef HIGHT_KS_DELTA_ROM_EN
        dl = lfsr_fwd(dl);
`endif
      end
    end
  end

endmodule

// File: tb/tb_hight_key_sched.sv
// Bench for hight_key_sched: LANES=4 and LANES=1 instances against a bit-sequence reference model.
module tb_hight_key_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start4, ed4, ready4;
  logic [127:0] mk4;
  logic [31:0]  pre4, post4, data4;
  logic         valid4, busy4, done4;

  logic         start1, ed1, ready1;
  logic [127:0] mk1;
  logic [31:0]  pre1, post1;
  logic [7:0]   data1;
  logic         valid1, busy1, done1;

  hight_key_sched #(.LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .ed(ed4), .MK(mk4),
    .wk_pre(pre4), .wk_post(post4), .sk_data(data4), .sk_valid(valid4),
    .sk_ready(ready4), .busy(busy4), .done(done4)
  );

  hight_key_sched #(.LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .ed(ed1), .MK(mk1),
    .wk_pre(pre1), .wk_post(post1), .sk_data(data1), .sk_valid(valid1),
    .sk_ready(ready1), .busy(busy1), .done(done1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0]  delta_ref [128];
  logic [31:0] got [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Deltas straight from the bit recurrence s(i+7) = s(i+3) ^ s(i), seeded by 0x5A.
  function automatic void build_ref();
    bit         s [134];
    logic [7:0] seed;
    seed = 8'h5A;
    for (int t = 0; t < 7; t++) s[t] = seed[t];
    for (int i = 0; i < 127; i++) s[i+7] = s[i+3] ^ s[i];
    for (int n = 0; n < 128; n++) begin
      delta_ref[n] = '0;
      for (int t = 0; t < 7; t++) delta_ref[n][t] = s[n+t];
    end
  endfunction

  function automatic logic [7:0] sk_ref(input logic [127:0] key, input int n);
    int i, j, idx;
    i   = n / 16;
    j   = n % 16;
    idx = (((j % 8) - i + 8) % 8) + ((j >= 8) ? 8 : 0);
    return key[8*idx +: 8] + delta_ref[n];
  endfunction

  function automatic logic [31:0] beat4_ref(input logic [127:0] key, input logic mode, input int b);
    logic [31:0] r;
    int g;
    g = mode ? b : 31 - b;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sk_ref(key, 4 * g + k);
    return r;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run4(input logic [127:0] key, input logic mode, input bit poke, input string tag);
    logic [31:0] exp_pre, exp_post;
    exp_pre  = mode ? key[127:96] : key[31:0];
    exp_post = mode ? key[31:0] : key[127:96];
    ready4 = 1'b1;
    start4 = 1'b1;
    ed4    = mode;
    mk4    = key;
    @(posedge clk); #1;
    start4 = 1'b0;
    mk4    = rand_key();
    ed4    = ~mode;
    check({tag, "_busy_t1"}, busy4, 1);
    check({tag, "_valid_t1"}, valid4, 0);
    @(posedge clk); #1;
    check({tag, "_wk_pre"}, pre4, exp_pre);
    check({tag, "_wk_post"}, post4, exp_post);
    for (int b = 0; b < 32; b++) begin
      if (poke && b == 5) start4 = 1'b1;
      check($sformatf("%s_valid_%0d", tag, b), valid4, 1);
      check($sformatf("%s_beat_%0d", tag, b), data4, beat4_ref(key, mode, b));
      got[b] = data4;
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    check({tag, "_done"}, done4, 1);
    check({tag, "_busy_done"}, busy4, 1);
    check({tag, "_valid_done"}, valid4, 0);
    if (poke) start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check({tag, "_done_drop"}, done4, 0);
    check({tag, "_busy_drop"}, busy4, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] kinc;
    logic [127:0] krnd;
    int           b, cyc;
    bit           acc, prev_stall;
    logic [7:0]   prev;

    build_ref();
    reset  = 1'b1;
    start4 = 1'b0; ed4 = 1'b0; mk4 = '0; ready4 = 1'b1;
    start1 = 1'b0; ed1 = 1'b0; mk1 = '0; ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wk_pre", pre4, 0);
    check("rst_wk_post", post4, 0);
    check("rst_data", data4, 0);
    check("rst_valid", valid4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_data1", data1, 0);
    check("rst_valid1", valid1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run4('0, 1'b1, 1'b0, "zero_enc");
    check("zero_enc_b0_lit", got[0], 32'h1B366D5A);
    check("zero_enc_b1_lit", got[1], 32'h4103060D);

    for (int k = 0; k < 16; k++) kinc[8*k +: 8] = 8'(k);
    run4(kinc, 1'b1, 1'b1, "inc_enc");
    check("inc_enc_b0_lit", got[0], 32'h1E386E5A);
    check("inc_enc_wk_pre_lit", pre4, 32'h0F0E0D0C);
    run4(kinc, 1'b0, 1'b0, "inc_dec");
    check("inc_dec_last_lit", got[31], 32'h1E386E5A);

    // Abandon a schedule after ten beats with a reset.
    krnd   = rand_key();
    start4 = 1'b1; ed4 = 1'b1; mk4 = krnd;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_beat10", data4, beat4_ref(krnd, 1'b1, 10));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_wk_pre", pre4, 0);
    check("rst_mid_wk_post", post4, 0);
    check("rst_mid_data", data4, 0);
    check("rst_mid_valid", valid4, 0);
    check("rst_mid_busy", busy4, 0);
    check("rst_mid_done", done4, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", done4, 0);
    end
    run4(rand_key(), 1'($urandom_range(0, 1)), 1'b0, "after_rst");

    // LANES=1 with random back-pressure.
    start1 = 1'b1; ed1 = 1'b1; mk1 = '0;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    b = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
    while (b < 128 && cyc < 2000) begin
      ready1 = ($urandom_range(0, 3) != 0);
      check("l1_valid", valid1, 1);
      check($sformatf("l1_beat_%0d", b), data1, sk_ref('0, b));
      if (prev_stall) check("l1_hold", data1, prev);
      prev       = data1;
      acc        = ready1;
      prev_stall = !ready1;
      @(posedge clk); #1;
      cyc++;
      if (acc) b++;
    end
    ready1 = 1'b0;
    check("l1_beat_count", b, 128);
    check("l1_done", done1, 1);
    @(posedge clk); #1;
    check("l1_done_drop", done1, 0);
    check("l1_busy_drop", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
